// File: rtl/seqgen_pkg.sv
// seqgen_pkg -- shared definitions for the sequence generator.
//   seq_state_e : controller states (IDLE, SEND, DONE)
//   SEQ_LEN     : number of symbols in one sequence repetition
//   SEQ_TABLE   : the fixed symbol sequence, index 0..SEQ_LEN-1; also used
//                 by the sequence detector's bench as the golden pattern
package seqgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int SEQ_LEN = 8;

  localparam logic [2:0] SEQ_TABLE [SEQ_LEN] = '{
    3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101
  };

endpackage

// File: rtl/seqgen_symbol_rom.sv
// seqgen_symbol_rom -- combinational lookup of one sequence symbol.
//   idx : input,  3 bits, symbol index 0..7
//   sym : output, 3 bits, symbol at that index
module seqgen_symbol_rom
  import seqgen_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] sym
);

  // Table lookup; every 3-bit index maps to a table entry.
  always_comb begin
    sym = SEQ_TABLE[idx];
  end

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator -- emits the fixed 8-symbol sequence REPEAT times per
// start request over a valid/ready handshake, then pulses done.
//   clk        : input,  rising-edge clock
//   reset      : input,  synchronous active-low reset
//   start      : input,  begin a burst (only honoured in IDLE)
//   data_ready : input,  sink accepts the current symbol (only used in SEND)
//   inject_err : input,  present only with SEQGEN_ERR_INJECT_EN; captured
//                with start, corrupts the final symbol of the burst
//   data       : output, 3-bit symbol (IDLE_SYM while data_valid is low)
//   data_valid : output, data holds a valid symbol
//   busy       : output, state is not IDLE
//   done       : output, one-cycle pulse after the last symbol transfers
// Optional feature macro: SEQGEN_ERR_INJECT_EN.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int         REPEAT   = 1,
  parameter logic [2:0] IDLE_SYM = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       data_ready,
`ifdef SEQGEN_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  output logic [2:0] data,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);
  localparam logic [7:0] LAST_REP = 8'(REPEAT - 1);

  seq_state_e state_r;
  logic [2:0] idx_r;
  logic [7:0] rep_r;
`ifdef SEQGEN_ERR_INJECT_EN
  logic       err_r;
`endif

  logic       xfer_s;
  logic       last_s;
  logic [2:0] next_idx_s;
  logic [7:0] next_rep_s;
  logic [2:0] rom_sym_s;
  logic [2:0] next_sym_s;

  // Handshake decode and the index/repetition of the symbol to present next.
  always_comb begin
    xfer_s     = (state_r == ST_SEND) && data_valid && data_ready;
    last_s     = xfer_s && (idx_r == LAST_IDX) && (rep_r == LAST_REP);
    next_idx_s = idx_r;
    next_rep_s = rep_r;
    if (state_r == ST_IDLE) begin
      next_idx_s = 3'd0;
      next_rep_s = 8'd0;
    end else if (xfer_s) begin
      // The 3-bit index wraps 7->0 naturally; the wrap bumps the repetition.
      next_idx_s = idx_r + 3'd1;
      if (idx_r == LAST_IDX) begin
        next_rep_s = rep_r + 8'd1;
      end else begin
        next_rep_s = rep_r;
      end
    end else begin
      next_idx_s = idx_r;
      next_rep_s = rep_r;
    end
  end

  seqgen_symbol_rom u_rom (
    .idx (next_idx_s),
    .sym (rom_sym_s)
  );

  // Symbol to load into the output register, with optional final-symbol
  // corruption.
  always_comb begin
    next_sym_s = rom_sym_s;
`ifdef SEQGEN_ERR_INJECT_EN
    if (err_r && (next_idx_s == LAST_IDX) && (next_rep_s == LAST_REP)) begin
      next_sym_s = rom_sym_s ^ 3'b001;
    end else begin
      next_sym_s = rom_sym_s;
    end
`endif
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      rep_r      <= 8'd0;
      data       <= IDLE_SYM;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQGEN_ERR_INJECT_EN
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= ST_SEND;
            idx_r      <= 3'd0;
            rep_r      <= 8'd0;
            data       <= next_sym_s;
            data_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef SEQGEN_ERR_INJECT_EN
            err_r      <= inject_err;
`endif
          end else begin
            state_r    <= ST_IDLE;
            data       <= IDLE_SYM;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_SEND: begin
          if (last_s) begin
            state_r    <= ST_DONE;
            idx_r      <= 3'd0;
            rep_r      <= 8'd0;
            data       <= IDLE_SYM;
            data_valid <= 1'b0;
            done       <= 1'b1;
          end else if (xfer_s) begin
            idx_r <= next_idx_s;
            rep_r <= next_rep_s;
            data  <= next_sym_s;
          end else begin
            // Stalled: hold data and data_valid until the sink accepts.
            idx_r <= idx_r;
            rep_r <= rep_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          idx_r      <= 3'd0;
          rep_r      <= 8'd0;
          data       <= IDLE_SYM;
          data_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator -- drives two generator instances (REPEAT=1 with the
// default idle symbol, REPEAT=3 with idle symbol 3'b111) from shared inputs.
// A transfer-counting reference model predicts every output every cycle;
// directed sections pin literal values for the basic burst, a stall, a
// mid-burst reset and ignored start pulses, followed by a random phase.
module tb_sequence_generator;

  localparam logic [2:0] SEQ_REF [8] = '{
    3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5
  };

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic data_ready = 1'b0;
`ifdef SEQGEN_ERR_INJECT_EN
  logic inject_err = 1'b0;
`endif

  logic [2:0] data1, data3;
  logic       valid1, valid3, busy1, busy3, done1, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_generator #(.REPEAT(1), .IDLE_SYM(3'b000)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_ready (data_ready),
`ifdef SEQGEN_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .data       (data1),
    .data_valid (valid1),
    .busy       (busy1),
    .done       (done1)
  );

  sequence_generator #(.REPEAT(3), .IDLE_SYM(3'b111)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_ready (data_ready),
`ifdef SEQGEN_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .data       (data3),
    .data_valid (valid3),
    .busy       (busy3),
    .done       (done3)
  );

  // Reference model: mode 0 idle, 1 sending, 2 done; pos counts symbols
  // already accepted in the current burst.
  int         reps     [2] = '{1, 3};
  logic [2:0] idle_sym [2] = '{3'b000, 3'b111};
  int         mode     [2] = '{0, 0};
  int         pos      [2] = '{0, 0};
  bit         err      [2] = '{1'b0, 1'b0};
  bit         started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_sym(input int d);
    logic [2:0] s;
    s = SEQ_REF[pos[d] % 8];
`ifdef SEQGEN_ERR_INJECT_EN
    if (err[d] && pos[d] == 8 * reps[d] - 1) s = s ^ 3'b001;
`endif
    return s;
  endfunction

  // Advance the model on every rising edge from the inputs the DUTs see.
  always @(posedge clk) begin
    started <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        mode[d] <= 0;
        pos[d]  <= 0;
      end else if (mode[d] == 0) begin
        if (start) begin
          mode[d] <= 1;
          pos[d]  <= 0;
`ifdef SEQGEN_ERR_INJECT_EN
          err[d]  <= inject_err;
`else
          err[d]  <= 1'b0;
`endif
        end
      end else if (mode[d] == 1) begin
        if (data_ready) begin
          pos[d] <= pos[d] + 1;
          if (pos[d] + 1 == 8 * reps[d]) mode[d] <= 2;
        end
      end else begin
        mode[d] <= 0;
      end
    end
  end

  task automatic compare_one(input int d, input logic [2:0] dat, input logic v,
                             input logic b, input logic dn);
    bit ev;
    ev = (mode[d] == 1);
    check($sformatf("valid[%0d]", d), int'(v), int'(ev));
    check($sformatf("data[%0d]", d), int'(dat), int'(ev ? exp_sym(d) : idle_sym[d]));
    check($sformatf("busy[%0d]", d), int'(b), int'(mode[d] != 0));
    check($sformatf("done[%0d]", d), int'(dn), int'(mode[d] == 2));
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      compare_one(0, data1, valid1, busy1, done1);
      compare_one(1, data3, valid3, busy3, done3);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_inject(input bit v);
`ifdef SEQGEN_ERR_INJECT_EN
    inject_err = v;
`else
    if (v) begin end
`endif
  endtask

  initial begin
    // Reset state.
    reset = 1'b0; start = 1'b0; data_ready = 1'b1; set_inject(1'b0);
    tick(); tick();
    check("rst_valid1", int'(valid1), 0);
    check("rst_data1", int'(data1), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_data3", int'(data3), 7);

    // Basic burst with back-to-back transfers; start pulses mid-burst and
    // in the DONE cycle must be ignored.
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = (i == 3);
      check($sformatf("burst_data[%0d]", i), int'(data1), int'(SEQ_REF[i]));
      check($sformatf("burst_valid[%0d]", i), int'(valid1), 1);
    end
    tick();
    check("burst_done", int'(done1), 1);
    check("burst_done_valid", int'(valid1), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("after_done", int'(done1), 0);
    check("after_busy", int'(busy1), 0);
    tick();
    check("done_start_ignored", int'(busy1), 0);
    repeat (30) tick();

    // Stall at index 2 for three cycles.
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_data[%0d]", i), int'(data1), 6);
      check($sformatf("stall_valid[%0d]", i), int'(valid1), 1);
    end
    data_ready = 1'b1;
    tick();
    check("stall_resume", int'(data1), 0);
    repeat (30) tick();

    // Reset at index 4 abandons the burst; the next start restarts at 001.
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    check("pre_reset_data", int'(data1), 6);
    reset = 1'b0;
    tick();
    check("midrst_valid", int'(valid1), 0);
    check("midrst_data", int'(data1), 0);
    check("midrst_busy", int'(busy1), 0);
    check("midrst_done", int'(done1), 0);
    reset = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("restart_data", int'(data1), 1);
    repeat (30) tick();

    // Randomised phase.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(7) == 0);
      data_ready = ($urandom_range(9) < 7);
      reset      = ($urandom_range(199) != 0);
      set_inject($urandom_range(1) == 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter REPEAT, default 1: number of back-to-back sequence repetitions per start; legal range 1..255.
REQ-002 SHALL have parameter IDLE_SYM, default 3'b000: value driven on data while data_valid is low.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one transmission burst; sampled only in IDLE.
REQ-006 SHALL have port data_ready, input, 1 bit: sink accepts the current symbol.
REQ-007 SHALL have port data, output, 3 bits: current symbol.
REQ-008 SHALL have port data_valid, output, 1 bit: data holds a valid symbol.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse on burst completion.

Function
REQ-011 SHALL emit the fixed 8-symbol sequence 001,101,110,000,110,110,011,101 (index 0..7), REPEAT times per burst.
REQ-012 SHALL implement states IDLE, SEND and DONE.
REQ-013 IDLE->SEND on a clk edge with start=1; data_valid SHALL be high with symbol 0 in the next cycle (1-cycle latency).
REQ-014 A symbol SHALL transfer when data_valid && data_ready on a rising edge; data SHALL be held stable while data_valid && !data_ready.
REQ-015 data_valid SHALL NOT drop before transfer; with data_ready tied high, one symbol SHALL transfer per cycle with no bubbles, including across repetition boundaries.
REQ-016 Symbol index SHALL be 3 bits and wrap 7->0; the repetition counter SHALL be 8 bits and increment on each wrap.
REQ-017 SEND->DONE on the transfer of index 7 of repetition REPEAT; DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-018 start while busy SHALL be ignored, not queued; start in the DONE cycle SHALL be ignored.
REQ-019 When data_valid=0, data SHALL equal IDLE_SYM.
REQ-020 data_ready SHALL be ignored outside SEND.

Reset
REQ-021 reset=0 at a clk edge SHALL force IDLE, index 0, repetition count 0, data_valid=0, data=IDLE_SYM, busy=0, done=0.
REQ-022 Reset mid-burst SHALL abandon the burst with no done pulse; the first post-reset start SHALL begin at symbol 0.
REQ-023 Reset SHALL take priority over start and data_ready in the same cycle.

Configuration
REQ-024 Macro SEQGEN_ERR_INJECT_EN, when defined, SHALL add input inject_err (1 bit), captured with start; when captured high, symbol index 7 of the final repetition SHALL be sent as 3'b100 (101 XOR 001).
REQ-025 Without SEQGEN_ERR_INJECT_EN, the port and logic SHALL be absent and every symbol SHALL be sent unmodified.

Structure
REQ-026 Package seqgen_pkg SHALL hold the state enum type, SEQ_LEN=8, and the 8-entry symbol constant table shared with the detector's bench.
REQ-027 Sub-module seqgen_symbol_rom (3-bit index in, 3-bit symbol out, combinational) SHALL be instantiated once.

Verification
REQ-028 REPEAT=1, data_ready=1, one-cycle start -> data 1,5,6,0,6,6,3,5 on 8 consecutive cycles, then done=1 for one cycle, then busy=0.
REQ-029 data_ready low for 3 cycles at index 2 -> data=3'b110 and data_valid=1 held for all 3 cycles; sequence resumes with 000.
REQ-030 REPEAT=3, data_ready=1 -> 24 consecutive valid symbols with no gap, one done pulse.
REQ-031 reset=0 at index 4 -> next cycle data_valid=0, data=IDLE_SYM, busy=0, no done; a new start restarts at 001.
REQ-032 Output looped into the sequence detector with data_ready=1 -> sequence_found high on the final symbol; with SEQGEN_ERR_INJECT_EN and inject_err=1 -> last symbol 3'b100 and sequence_found stays low.
REQ-033 start pulsed during SEND and during DONE -> no effect; exactly 8*REPEAT transfers per accepted start.
